// File: rtl/ram_burst_ctrl.sv
// Burst controller between a command/stream interface and a single-port synchronous RAM.
// Reads are buffered in a 2-entry FIFO so rdata backpressure never loses a word.
module ram_burst_ctrl #(
    parameter int unsigned Width  = 32,
    parameter int unsigned Depth  = 256,
    parameter int unsigned MaxLen = 16,
    localparam int unsigned Aw    = $clog2(Depth),
    localparam int unsigned LenW  = $clog2(MaxLen)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_write_i,
    input  logic [Aw-1:0]    cmd_addr_i,
    input  logic [LenW-1:0]  cmd_len_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rdata_valid_o,
    input  logic             rdata_ready_i,
    output logic [Width-1:0] rdata_o,
    output logic             rdata_last_o,
    output logic             busy_o,
    output logic             ram_we_o,
    output logic             ram_re_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    input  logic [Width-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

    state_e          state_q;
    logic [Aw-1:0]   addr_q;
    logic [Aw-1:0]   addr_next;
    logic [LenW-1:0] remain_q;
    logic            last_beat;
    logic            inflight_q;
    logic            inflight_last_q;

    logic [Width-1:0] fifo_data_q [2];
    logic [1:0]       fifo_last_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;
    logic [2:0]       occupancy;

    assign addr_next = (addr_q == Aw'(Depth - 1)) ? '0 : addr_q + 1'b1;
    assign last_beat = (remain_q == '0);

    assign cmd_ready_o   = (state_q == StIdle);
    assign busy_o        = (state_q != StIdle);
    assign wdata_ready_o = (state_q == StWrite);
    assign ram_we_o      = (state_q == StWrite) && wdata_valid_i;
    assign ram_wdata_o   = wdata_i;
    assign ram_addr_o    = addr_q;

    assign rdata_valid_o = (count_q != 2'd0);
    assign rdata_o       = rdata_valid_o ? fifo_data_q[rd_ptr_q] : '0;
    assign rdata_last_o  = rdata_valid_o & fifo_last_q[rd_ptr_q];

    assign pop  = rdata_valid_o & rdata_ready_i;
    assign push = inflight_q;

    // Words already buffered or on their way, after this cycle's pop; caps at the FIFO depth.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign ram_re_o  = (state_q == StRead) && (occupancy < 3'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        addr_q   <= cmd_addr_i;
                        remain_q <= cmd_len_i;
                        state_q  <= cmd_write_i ? StWrite : StRead;
                    end
                end
                StWrite: begin
                    if (wdata_valid_i) begin
                        addr_q   <= addr_next;
                        remain_q <= remain_q - 1'b1;
                        if (last_beat) state_q <= StIdle;
                    end
                end
                StRead: begin
                    if (ram_re_o) begin
                        addr_q   <= addr_next;
                        remain_q <= remain_q - 1'b1;
                        if (last_beat) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (count_q == 2'd0 && !inflight_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_last_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            inflight_q      <= ram_re_o;
            inflight_last_q <= ram_re_o & last_beat;
            if (push) begin
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage needs no reset; rdata_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) fifo_data_q[wr_ptr_q] <= ram_rdata_i;
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural single-port RAM (1-cycle read latency).
module tb_ram_burst_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic [31:0] rdata;
    logic        rdata_last;
    logic        busy;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [256];

    int passed = 0;
    int total  = 0;

    ram_burst_ctrl #(
        .Width (32),
        .Depth (256),
        .MaxLen(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .wdata_valid_i(wdata_valid),
        .wdata_ready_o(wdata_ready),
        .wdata_i      (wdata),
        .rdata_valid_o(rdata_valid),
        .rdata_ready_i(rdata_ready),
        .rdata_o      (rdata),
        .rdata_last_o (rdata_last),
        .busy_o       (busy),
        .ram_we_o     (ram_we),
        .ram_re_o     (ram_re),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 30) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  vpat;
        logic [7:0]  wrap_addr [4];
        logic [31:0] bp_exp [8];
        int          k;
        int          we_cnt;
        int          re_cnt;
        int          got;

        for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 + i;
        ram_rdata   = '0;
        wrap_addr   = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        bp_exp      = '{32'hB0, 32'hB1, 32'hB2, 32'hB3,
                        32'hC000_0002, 32'hC000_0003, 32'hC000_0004, 32'hC000_0005};
        vpat        = 6'b110011;  // bit c = valid in write cycle c+1
        rst_n       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b0;

        // Reset asserted mid-cycle: outputs settle immediately.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_rdata_last", {31'd0, rdata_last}, 32'd0);
        chk("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_re", {31'd0, ram_re}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Write 0x10 len 3 with a 2-cycle gap; a read command is held during the burst.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h10;
        cmd_len   = 4'd3;
        #1;
        chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        k      = 0;
        we_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cmd_valid   = 1'b1;
            cmd_write   = 1'b0;
            cmd_addr    = 8'h10;
            cmd_len     = 4'd3;
            wdata_valid = vpat[c];
            wdata       = 32'hA0 + k;
            #1;
            chk("wr_busy", {31'd0, busy}, 32'd1);
            chk("wr_held_cmd_ignored", {31'd0, cmd_ready}, 32'd0);
            chk("wr_wdata_ready", {31'd0, wdata_ready}, 32'd1);
            chk("wr_no_re", {31'd0, ram_re}, 32'd0);
            if (vpat[c]) begin
                chk("wr_addr", {24'd0, ram_addr}, 32'h10 + k);
                k++;
            end
            we_cnt += int'(ram_we);
        end
        @(negedge clk);
        wdata_valid = 1'b0;
        rdata_ready = 1'b1;
        #1;
        we_cnt += int'(ram_we);
        chk("wr_busy_fell", {31'd0, busy}, 32'd0);
        chk("wr_we_count", we_cnt, 32'd4);
        chk("held_cmd_accept", {31'd0, cmd_ready}, 32'd1);

        // Held read 0x10 len 3 is handshaken this cycle (cycle 0).
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (c == 1) begin
                chk("rd_first_re", {31'd0, ram_re}, 32'd1);
                chk("rd_first_addr", {24'd0, ram_addr}, 32'h10);
                chk("rd_no_we", {31'd0, ram_we}, 32'd0);
            end
            chk("rd_valid", {31'd0, rdata_valid}, {31'd0, (c >= 3 && c <= 6)});
            if (c >= 3 && c <= 6) chk("rd_data", rdata, 32'hA0 + (c - 3));
            chk("rd_last", {31'd0, rdata_last}, {31'd0, (c == 6)});
        end
        wait_idle();

        // Wrap: write 0xFE len 3.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'hFE;
        cmd_len   = 4'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            cmd_valid   = 1'b0;
            wdata_valid = 1'b1;
            wdata       = 32'hB0 + c;
            #1;
            chk("wrap_addr", {24'd0, ram_addr}, {24'd0, wrap_addr[c]});
            chk("wrap_we", {31'd0, ram_we}, 32'd1);
        end
        @(negedge clk);
        wdata_valid = 1'b0;
        #1;
        chk("wrap_done", {31'd0, busy}, 32'd0);

        // Backpressure: read 0xFE len 7 with rdata_ready low for 6 cycles.
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_addr    = 8'hFE;
        cmd_len     = 4'd7;
        rdata_ready = 1'b0;
        re_cnt      = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            re_cnt += int'(ram_re);
        end
        chk("bp_re_bounded", {31'd0, (re_cnt <= 2)}, 32'd1);
        chk("bp_head_valid", {31'd0, rdata_valid}, 32'd1);
        chk("bp_head_data", rdata, 32'hB0);
        got = 0;
        for (int t = 0; t < 40 && got < 8; t++) begin
            @(negedge clk);
            rdata_ready = 1'b1;
            #1;
            if (rdata_valid) begin
                chk("bp_data", rdata, bp_exp[got]);
                chk("bp_last", {31'd0, rdata_last}, {31'd0, (got == 7)});
                got++;
            end
        end
        chk("bp_word_count", got, 32'd8);
        wait_idle();
        chk("bp_no_extra", {31'd0, rdata_valid}, 32'd0);

        // Reset while beat 2 of a len-7 read is being issued.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        cmd_len   = 4'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_re_before", {31'd0, ram_re}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_re", {31'd0, ram_re}, 32'd0);
        chk("mid_rst_valid", {31'd0, rdata_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        #1;
        chk("mid_rst_held_re", {31'd0, ram_re}, 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_addr    = 8'h20;
        cmd_len     = 4'd0;
        wdata_valid = 1'b1;
        wdata       = 32'hD5;
        #1;
        chk("post_mid_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("post_mid_we", {31'd0, ram_we}, 32'd1);
        chk("post_mid_addr", {24'd0, ram_addr}, 32'h20);
        chk("post_mid_wdata", ram_wdata, 32'hD5);
        @(negedge clk);
        wdata_valid = 1'b0;
        #1;
        chk("post_mid_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
